// File: rtl/fpu_pkg.sv
// Shared FPU datapath definitions: mantissa width and the common
// IDLE/CALC/DONE sequencing states used by the multiplier and divider.
package fpu_pkg;

    localparam int MANT_W = 24;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/multiplier_24bit.sv
// Sequential shift-add mantissa multiplier: one partial product per cycle,
// then the 2N-bit product is normalized and truncated to an N-1 bit fraction.
module multiplier_24bit
    import fpu_pkg::*;
#(
    parameter int N = MANT_W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product,
    output logic [N-2:0]   mantissa,
    output logic           normalize
);

    localparam int CW = $clog2(N);

    state_t          state;
    logic [N-1:0]    m;
    logic [N-1:0]    acc;
    logic [N-1:0]    q;
    logic [CW-1:0]   cnt;

    // sum[N] is the carry out of the add; shifting {carry,A,Q} right by one
    // is just re-slicing {sum, Q[N-1:1]}.
    logic [N:0]      sum;
    logic [2*N-1:0]  nxt;

    always_comb begin
        sum = {1'b0, acc} + (q[0] ? {1'b0, m} : {(N+1){1'b0}});
        nxt = {sum, q[N-1:1]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            m         <= '0;
            acc       <= '0;
            q         <= '0;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            product   <= '0;
            mantissa  <= '0;
            normalize <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        m     <= a;
                        q     <= b;
                        acc   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= CALC;
                    end
                end
                CALC: begin
                    acc <= nxt[2*N-1:N];
                    q   <= nxt[N-1:0];
                    cnt <= cnt + 1'b1;
                    // Last iteration: publish the finished product directly.
                    if (cnt == CW'(N-1)) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        product   <= nxt;
                        normalize <= nxt[2*N-1];
                        mantissa  <= nxt[2*N-1] ? nxt[2*N-2:N] : nxt[2*N-3:N-1];
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multiplier_24bit.sv
// Scoreboard bench: the driver predicts each accepted operation from plain
// integer multiplication; a negedge monitor checks every done pulse and busy.
module tb_multiplier_24bit;

    localparam int N = 24;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [N-1:0]   a = '0;
    logic [N-1:0]   b = '0;
    logic           busy;
    logic           done;
    logic [2*N-1:0] product;
    logic [N-2:0]   mantissa;
    logic           normalize;

    multiplier_24bit #(.N(N)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .product(product),
        .mantissa(mantissa), .normalize(normalize)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int             exp_cyc;
        logic [2*N-1:0] p;
        logic [N-2:0]   m;
        logic           nz;
    } exp_t;

    exp_t sb[$];
    int   free_at   = 0;
    int   busy_from = -1;
    int   busy_to   = -2;
    int   n_chk     = 0;
    int   n_fail    = 0;
    logic [2*N-1:0] hold_p  = '0;
    logic [N-2:0]   hold_m  = '0;
    logic           hold_nz = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [N-1:0] x, input logic [N-1:0] y, input int acc_cyc);
        exp_t e;
        logic [63:0] p64;
        p64 = 64'(x) * 64'(y);
        e.exp_cyc = acc_cyc + N + 1;
        e.p  = (2*N)'(p64);
        e.nz = (p64 >= (64'd1 << (2*N-1)));
        e.m  = e.nz ? (N-1)'(p64 >> N) : (N-1)'(p64 >> (N-1));
        return e;
    endfunction

    // Called right after a negedge; the start is sampled at the next posedge.
    task automatic drive(input logic [N-1:0] x, input logic [N-1:0] y);
        start = 1'b1;
        a = x;
        b = y;
        if (cyc >= free_at) begin
            sb.push_back(model(x, y, cyc));
            busy_from = cyc + 1;
            busy_to   = cyc + N;
            free_at   = cyc + N + 2;
        end
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        start = 1'b0;
        a = N'($urandom);
        b = N'($urandom);
    endtask

    task automatic wait_idle();
        int guard = 0;
        while (cyc < free_at && guard < 200) begin
            idle_cycle();
            guard++;
        end
    endtask

    task automatic do_op(input logic [N-1:0] x, input logic [N-1:0] y);
        drive(x, y);
        idle_cycle();
        wait_idle();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_product"}, 64'(product), 64'd0);
        chk({tag, "_mantissa"}, 64'(mantissa), 64'd0);
        chk({tag, "_normalize"}, 64'(normalize), 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_zero("async_rst");
        sb.delete();
        free_at = 0; busy_from = -1; busy_to = -2;
        hold_p = '0; hold_m = '0; hold_nz = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        start = 1'b0;
    endtask

    function automatic logic [N-1:0] rnd_op();
        case ($urandom % 8)
            0:       return '0;
            1:       return '1;
            2:       return {1'b1, {(N-1){1'b0}}};
            3:       return N'($urandom);
            default: return N'($urandom) | {1'b1, {(N-1){1'b0}}};
        endcase
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            chk("busy", 64'(busy), 64'(cyc >= busy_from && cyc <= busy_to));
            if (sb.size() > 0 && sb[0].exp_cyc < cyc) begin
                n_chk++; n_fail++;
                $display("FAIL missing_done: no done pulse, expected at cycle %0d", sb[0].exp_cyc);
                void'(sb.pop_front());
            end
            if (done) begin
                if (sb.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL spurious_done: done=1 with nothing outstanding (cycle %0d)", cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("done_cycle", 64'(cyc), 64'(e.exp_cyc));
                    chk("product", 64'(product), 64'(e.p));
                    chk("mantissa", 64'(mantissa), 64'(e.m));
                    chk("normalize", 64'(normalize), 64'(e.nz));
                    hold_p = e.p; hold_m = e.m; hold_nz = e.nz;
                end
            end else begin
                chk("hold_product", 64'(product), 64'(hold_p));
                chk("hold_mant_norm", 64'({normalize, mantissa}), 64'({hold_nz, hold_m}));
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        check_zero("reset_state");
        #2 rst = 1'b0;
        @(negedge clk);

        do_op(24'h800000, 24'h800000);
        do_op(24'hC00000, 24'hC00000);
        do_op(24'hFFFFFF, 24'hFFFFFF);
        do_op(24'h000000, 24'hABCDEF);

        // Second start while busy must be ignored.
        drive(24'h800000, 24'hC00000);
        repeat (4) idle_cycle();
        @(negedge clk);
        drive(24'hFFFFFF, 24'hFFFFFF);
        idle_cycle();
        wait_idle();

        // Start on the very first IDLE cycle after DONE.
        drive(24'hABCDEF, 24'h812345);
        idle_cycle();
        wait_idle();
        drive(24'hFEDCBA, 24'h9ABCDE);
        idle_cycle();
        wait_idle();

        // Abort mid-operation, then a fresh operation.
        drive(24'hC00000, 24'hE00000);
        repeat (9) idle_cycle();
        do_reset();
        @(negedge clk);
        do_op(24'h800000, 24'h800000);

        // start held high continuously: only IDLE cycles accept.
        for (int i = 0; i < 90; i++) begin
            @(negedge clk);
            drive(rnd_op(), rnd_op());
        end
        idle_cycle();

        // Random start pulses.
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if ($urandom % 3 == 0) drive(rnd_op(), rnd_op());
            else begin start = 1'b0; a = N'($urandom); b = N'($urandom); end
        end
        idle_cycle();
        repeat (N + 4) idle_cycle();

        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d operations outstanding, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/multiplier_24bit.md
MULTIPLIER_24BIT -- requirements
Module: multiplier_24bit

Interface
REQ-001: Parameter N, default 24, mantissa width including hidden bit.
REQ-002: clk  input  1  sole clock; all state updates on rising edge.
REQ-003: rst  input  1  asynchronous, active-high reset.
REQ-004: start  input  1  request; sampled only in IDLE.
REQ-005: a  input  N  multiplicand mantissa (hidden bit at [N-1]); captured when start is accepted.
REQ-006: b  input  N  multiplier mantissa; captured when start is accepted.
REQ-007: busy  output  1  high from the cycle after acceptance until done is asserted.
REQ-008: done  output  1  single-cycle pulse; result outputs valid in and after this cycle.
REQ-009: product  output  2N  full unsigned product a*b.
REQ-010: mantissa  output  N-1  normalized, truncated fraction (hidden bit dropped).
REQ-011: normalize  output  1  high when product[2N-1]=1; exponent must be incremented by 1.

Function
REQ-012: States: IDLE, CALC, DONE; IDLE->CALC on start, CALC->DONE when the iteration counter reaches N-1, DONE->IDLE unconditionally.
REQ-013: Acceptance cycle (start=1 in IDLE) is cycle 0; latch M=a, Q=b, A=0, carry=0, counter=0; busy=1 from cycle 1.
REQ-014: Each CALC cycle: if Q[0]=1 then {carry,A}=A+M (N+1-bit add), else {carry,A}=A; then shift {carry,A,Q} right by one bit; counter increments.
REQ-015: Exactly N CALC cycles (cycles 1..N); DONE in cycle N+1: done=1, busy=0, product={A,Q}.
REQ-016: Normalization in DONE: product[2N-1]=1 -> mantissa=product[2N-2:N], normalize=1; else mantissa=product[2N-3:N-1], normalize=0.
REQ-017: Truncation only; no rounding, guard or sticky bits.
REQ-018: product, mantissa and normalize hold their values until the next DONE or reset.
REQ-019: start while busy or in DONE is ignored; a/b changes after acceptance do not affect the result.
REQ-020: Zero operand is not special-cased; it yields product=0, normalize=0, mantissa=0 after the normal latency.
REQ-021: Back-to-back: start asserted in the cycle after DONE (IDLE) is accepted; minimum initiation interval N+2 cycles.

Reset
REQ-022: On rst=1, immediately and asynchronously: state=IDLE, busy=0, done=0, product=0, mantissa=0, normalize=0, counter=0, A/Q/M/carry=0.
REQ-023: Reset during CALC aborts the operation; no done pulse for it; the next start after rst deasserts begins a fresh operation.

Structure
REQ-024: State enum type and constant MANT_W=24 reside in shared package fpu_pkg, which the divider and other FPU datapath blocks also use.
REQ-025: No sub-module; a single sequential process plus combinational N+1-bit adder; no combinational path from inputs to outputs.

Verification
REQ-026: a=b=0x800000 (1.0*1.0), start for 1 cycle -> done in exactly cycle 25; product=0x400000000000, normalize=0, mantissa=0x000000.
REQ-027: a=b=0xC00000 (1.5*1.5) -> product=0x900000000000, normalize=1, mantissa=0x100000.
REQ-028: a=b=0xFFFFFF -> product=0xFFFFFE000001, normalize=1, mantissa=0x7FFFFE; busy high cycles 1..24 only.
REQ-029: a=0x800000, b=0xC00000 accepted; at cycle 5 start=1 with a=b=0xFFFFFF -> second start ignored; result product=0x600000000000, normalize=0, mantissa=0x400000.
REQ-030: rst asserted at cycle 10 of an operation -> all outputs 0 at once, no done pulse; new start of 0x800000*0x800000 after release -> correct result 25 cycles later.
REQ-031: a=0, b=0xABCDEF -> product=0, normalize=0, mantissa=0, done in cycle 25.
